// File: rtl/wb_arb_pkg.sv
// Shared definitions for the three-master Wishbone bus arbiter.
//
// Contents:
//   N_MASTERS    - number of bus masters sharing the interconnect port
//   GNT_W        - width of the one-hot grant vector
//   WDOG_W       - width of the stalled-cycle watchdog counter
//   gnt_t        - one-hot grant type (bit k = master k owns the bus)
//   arb_state_t  - arbiter states: IDLE (no owner) / OWNED (bus held)
//   onehot_to_idx- converts a one-hot grant into a master index
package wb_arb_pkg;

  localparam int N_MASTERS = 3;
  localparam int GNT_W     = N_MASTERS;
  localparam int WDOG_W    = 8;

  typedef logic [GNT_W-1:0] gnt_t;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  // An all-zero input maps to index 0; callers only use the result when
  // the vector is known to be non-zero.
  function automatic logic [1:0] onehot_to_idx(input gnt_t g);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (g[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wb_arb_rr_pick.sv
// Combinational rotating-priority picker.
//
// Ports:
//   req  [2:0] in  - request vector (one bit per master)
//   last [1:0] in  - index of the most recently granted master
//   pick [2:0] out - one-hot winner, zero when nothing is requested
//   any        out - at least one request is present
//
// The search starts just after 'last' and wraps, so the master that was
// served last has the lowest priority on the next decision.
module wb_arb_rr_pick
  import wb_arb_pkg::*;
(
  input  logic [N_MASTERS-1:0] req,
  input  logic [1:0]           last,
  output logic [N_MASTERS-1:0] pick,
  output logic                 any
);

  // Walk the candidates in order last+1, last+2, last (mod N_MASTERS)
  // and keep only the first one that is requesting.
  always_comb begin
    logic [1:0] cand;
    pick = '0;
    cand = '0;
    for (int i = 1; i <= N_MASTERS; i++) begin
      cand = 2'((32'(last) + i) % N_MASTERS);
      if (pick == '0 && req[cand]) pick[cand] = 1'b1;
    end
    any = |req;
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Round-robin Wishbone arbiter: three masters share one master port of the
// system interconnect. A master owns the bus from grant until it drops cyc;
// a watchdog terminates slave cycles that never ack with err.
//
// Parameters: ADR_W address width, DAT_W data width, TIMEOUT stalled stb
//             cycles before the watchdog fires (2..255).
// Ports:
//   clk, rst (async, active low)
//   m_adr_i/m_dat_i/m_sel_i     flattened per-master request payload
//   m_we_i/m_cyc_i/m_stb_i      per-master control
//   m_dat_o                     read data, shared by all masters
//   m_ack_o/m_err_o             per-master termination
//   s_adr_o..s_stb_o            muxed bus towards the address decoder
//   s_dat_i/s_ack_i             slave response
//   gnt_o                       one-hot current owner, zero when idle
//   timeout_o                   one-cycle pulse when the watchdog fires
module wb_bus_arbiter
  import wb_arb_pkg::*;
#(
  parameter int ADR_W   = 32,
  parameter int DAT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_MASTERS*ADR_W-1:0]     m_adr_i,
  input  logic [N_MASTERS*DAT_W-1:0]     m_dat_i,
  input  logic [N_MASTERS*(DAT_W/8)-1:0] m_sel_i,
  input  logic [N_MASTERS-1:0]           m_we_i,
  input  logic [N_MASTERS-1:0]           m_cyc_i,
  input  logic [N_MASTERS-1:0]           m_stb_i,
  output logic [DAT_W-1:0]               m_dat_o,
  output logic [N_MASTERS-1:0]           m_ack_o,
  output logic [N_MASTERS-1:0]           m_err_o,
  output logic [ADR_W-1:0]               s_adr_o,
  output logic [DAT_W-1:0]               s_dat_o,
  output logic [DAT_W/8-1:0]             s_sel_o,
  output logic                           s_we_o,
  output logic                           s_cyc_o,
  output logic                           s_stb_o,
  input  logic [DAT_W-1:0]               s_dat_i,
  input  logic                           s_ack_i,
  output logic [N_MASTERS-1:0]           gnt_o,
  output logic                           timeout_o
);

  localparam int                SEL_W      = DAT_W / 8;
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT - 1);

  arb_state_t        state, state_next;
  gnt_t              gnt, gnt_next;
  logic [1:0]        last, last_next;
  logic [WDOG_W-1:0] wdog, wdog_next;

  gnt_t pick;
  logic any;
  logic owner_cyc;
  logic owner_stb;
  logic rearb;
  logic fire;

  wb_arb_rr_pick u_pick (
    .req  (m_cyc_i),
    .last (last),
    .pick (pick),
    .any  (any)
  );

  // State, owner, last-granted index and watchdog. 'last' restarts at 2 so
  // master 0 wins the first arbitration after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      gnt   <= '0;
      last  <= 2'd2;
      wdog  <= '0;
    end else begin
      state <= state_next;
      gnt   <= gnt_next;
      last  <= last_next;
      wdog  <= wdog_next;
    end
  end

  // Next-state logic. Arbitration happens in IDLE and on the edge where the
  // owner releases cyc, so the next owner is registered with no idle bubble.
  // A stb left high while cyc drops is simply a release. The watchdog only
  // fires on a live cycle (owner cyc high); an ack in the same cycle wins.
  always_comb begin
    state_next = state;
    gnt_next   = gnt;
    last_next  = last;
    wdog_next  = wdog;
    owner_cyc  = |(m_cyc_i & gnt);
    owner_stb  = |(m_stb_i & gnt);
    fire       = (state == OWNED) && owner_cyc && owner_stb && !s_ack_i
                 && (wdog == WDOG_LIMIT);

    unique case (state)
      IDLE:    rearb = 1'b1;
      OWNED:   rearb = !owner_cyc;
      default: rearb = 1'b1;
    endcase

    if (rearb) begin
      wdog_next = '0;
      if (any) begin
        state_next = OWNED;
        gnt_next   = pick;
        last_next  = onehot_to_idx(pick);
      end else begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    end else if (s_ack_i || fire) begin
      wdog_next = '0;
    end else if (owner_stb) begin
      wdog_next = wdog + 1'b1;
    end
  end

  // Output muxes. Everything is derived from the registered one-hot grant,
  // which is zero in IDLE and under reset, so the bus side reads all zeros
  // then. A watchdog hit drops cyc/stb towards the slave for that cycle.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (gnt[k]) begin
        s_adr_o = m_adr_i[k*ADR_W +: ADR_W];
        s_dat_o = m_dat_i[k*DAT_W +: DAT_W];
        s_sel_o = m_sel_i[k*SEL_W +: SEL_W];
        s_we_o  = m_we_i[k];
      end
    end
    s_cyc_o   = owner_cyc & ~fire;
    s_stb_o   = owner_stb & ~fire;
    m_dat_o   = s_dat_i;
    m_ack_o   = gnt & {N_MASTERS{s_ack_i}};
    m_err_o   = gnt & {N_MASTERS{fire}};
    timeout_o = fire;
    gnt_o     = gnt;
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Self-checking bench for wb_bus_arbiter: a table of hand-computed vectors,
// hand-written watchdog and reset sequences, then randomized traffic
// compared against a transaction-level reference model.
module tb_wb_bus_arbiter;

  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int SEL_W = DAT_W / 8;
  localparam int NM    = 3;
  localparam int TMO   = 16;

  logic                clk;
  logic                rst;
  logic [NM*ADR_W-1:0] m_adr_i;
  logic [NM*DAT_W-1:0] m_dat_i;
  logic [NM*SEL_W-1:0] m_sel_i;
  logic [NM-1:0]       m_we_i;
  logic [NM-1:0]       m_cyc_i;
  logic [NM-1:0]       m_stb_i;
  logic [DAT_W-1:0]    m_dat_o;
  logic [NM-1:0]       m_ack_o;
  logic [NM-1:0]       m_err_o;
  logic [ADR_W-1:0]    s_adr_o;
  logic [DAT_W-1:0]    s_dat_o;
  logic [SEL_W-1:0]    s_sel_o;
  logic                s_we_o;
  logic                s_cyc_o;
  logic                s_stb_o;
  logic [DAT_W-1:0]    s_dat_i;
  logic                s_ack_i;
  logic [NM-1:0]       gnt_o;
  logic                timeout_o;

  wb_bus_arbiter #(
    .ADR_W   (ADR_W),
    .DAT_W   (DAT_W),
    .TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m_adr_i   (m_adr_i),
    .m_dat_i   (m_dat_i),
    .m_sel_i   (m_sel_i),
    .m_we_i    (m_we_i),
    .m_cyc_i   (m_cyc_i),
    .m_stb_i   (m_stb_i),
    .m_dat_o   (m_dat_o),
    .m_ack_o   (m_ack_o),
    .m_err_o   (m_err_o),
    .s_adr_o   (s_adr_o),
    .s_dat_o   (s_dat_o),
    .s_sel_o   (s_sel_o),
    .s_we_o    (s_we_o),
    .s_cyc_o   (s_cyc_o),
    .s_stb_o   (s_stb_o),
    .s_dat_i   (s_dat_i),
    .s_ack_i   (s_ack_i),
    .gnt_o     (gnt_o),
    .timeout_o (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  cyc;
    logic [2:0]  stb;
    logic        ack;
    logic [2:0]  gnt;
    logic [2:0]  acko;
    logic [2:0]  erro;
    logic        sstb;
    logic [31:0] adr;
    logic        tmo;
  } vec_t;

  vec_t vecs[20];

  // Reference model state: owner index (-1 = bus idle), last granted
  // master, and number of unanswered stb cycles of the current owner.
  int m_owner;
  int m_last;
  int m_cnt;

  logic [2:0] rnd_cyc;
  logic [2:0] rnd_stb;
  logic       rnd_ack;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] cyc, input logic [2:0] stb, input logic ack);
    m_cyc_i = cyc;
    m_stb_i = stb;
    s_ack_i = ack;
  endtask

  task automatic loadFixedPayload;
    m_adr_i = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000};
    m_dat_i = {32'hDDDD_0002, 32'hDDDD_0001, 32'hDDDD_0000};
    m_sel_i = 12'hF31;
    m_we_i  = 3'b101;
    s_dat_i = 32'hCAFE_0000;
  endtask

  function automatic bit bitOf(input logic [2:0] v, input int k);
    logic [1:0] i;
    i = k[1:0];
    return v[i] == 1'b1;
  endfunction

  task automatic modelReset;
    m_owner = -1;
    m_last  = 2;
    m_cnt   = 0;
  endtask

  function automatic bit modelFire();
    if (m_owner < 0) return 1'b0;
    return bitOf(m_cyc_i, m_owner) && bitOf(m_stb_i, m_owner) && !s_ack_i && (m_cnt == TMO - 1);
  endfunction

  // Advance the model across one clock edge using the inputs of the cycle
  // that just ended.
  task automatic modelStep;
    bit f;
    int nxt;
    f   = modelFire();
    nxt = -1;
    if (m_owner < 0 || !bitOf(m_cyc_i, m_owner)) begin
      for (int j = 1; j <= NM; j++) begin
        int c;
        c = (m_last + j) % NM;
        if (nxt < 0 && bitOf(m_cyc_i, c)) nxt = c;
      end
      m_owner = nxt;
      if (nxt >= 0) m_last = nxt;
      m_cnt = 0;
    end else if (s_ack_i || f) begin
      m_cnt = 0;
    end else if (bitOf(m_stb_i, m_owner)) begin
      m_cnt++;
    end
  endtask

  task automatic checkAgainstModel(input int n);
    bit               f;
    logic [2:0]       eg, ea, ee;
    logic             ecyc, estb, ewe;
    logic [ADR_W-1:0] eadr;
    logic [DAT_W-1:0] edat;
    logic [SEL_W-1:0] esel;
    f = modelFire();
    eg = '0; ea = '0; ee = '0;
    ecyc = 1'b0; estb = 1'b0; ewe = 1'b0;
    eadr = '0; edat = '0; esel = '0;
    if (m_owner >= 0) begin
      eg   = 3'(1 << m_owner);
      eadr = ADR_W'(m_adr_i >> (m_owner * ADR_W));
      edat = DAT_W'(m_dat_i >> (m_owner * DAT_W));
      esel = SEL_W'(m_sel_i >> (m_owner * SEL_W));
      ewe  = bitOf(m_we_i, m_owner);
      ecyc = bitOf(m_cyc_i, m_owner) && !f;
      estb = bitOf(m_stb_i, m_owner) && !f;
      ea   = s_ack_i ? eg : 3'b000;
      ee   = f ? eg : 3'b000;
    end
    checkOutput($sformatf("rnd%0d gnt", n),   64'(gnt_o),     64'(eg));
    checkOutput($sformatf("rnd%0d s_adr", n), 64'(s_adr_o),   64'(eadr));
    checkOutput($sformatf("rnd%0d s_dat", n), 64'(s_dat_o),   64'(edat));
    checkOutput($sformatf("rnd%0d s_sel", n), 64'(s_sel_o),   64'(esel));
    checkOutput($sformatf("rnd%0d s_we", n),  64'(s_we_o),    64'(ewe));
    checkOutput($sformatf("rnd%0d s_cyc", n), 64'(s_cyc_o),   64'(ecyc));
    checkOutput($sformatf("rnd%0d s_stb", n), 64'(s_stb_o),   64'(estb));
    checkOutput($sformatf("rnd%0d m_dat", n), 64'(m_dat_o),   64'(s_dat_i));
    checkOutput($sformatf("rnd%0d ack", n),   64'(m_ack_o),   64'(ea));
    checkOutput($sformatf("rnd%0d err", n),   64'(m_err_o),   64'(ee));
    checkOutput($sformatf("rnd%0d tmo", n),   64'(timeout_o), 64'(f));
  endtask

  // Grab the bus for 'victim', then assert reset in the middle of an acked
  // stb cycle; afterwards all three request and master 0 must win.
  task automatic resetMidCycle(input int victim);
    logic [2:0] v;
    v = 3'(1 << victim);
    applyStimulus(v, v, 1'b0);
    tick;
    applyStimulus(v, v, 1'b1);
    #2;
    checkOutput($sformatf("rst%0d owned gnt", victim), 64'(gnt_o), 64'(v));
    rst = 1'b0;
    #1;
    checkOutput($sformatf("rst%0d gnt", victim),   64'(gnt_o),     64'(0));
    checkOutput($sformatf("rst%0d s_cyc", victim), 64'(s_cyc_o),   64'(0));
    checkOutput($sformatf("rst%0d s_stb", victim), 64'(s_stb_o),   64'(0));
    checkOutput($sformatf("rst%0d s_adr", victim), 64'(s_adr_o),   64'(0));
    checkOutput($sformatf("rst%0d s_dat", victim), 64'(s_dat_o),   64'(0));
    checkOutput($sformatf("rst%0d ack", victim),   64'(m_ack_o),   64'(0));
    checkOutput($sformatf("rst%0d err", victim),   64'(m_err_o),   64'(0));
    checkOutput($sformatf("rst%0d tmo", victim),   64'(timeout_o), 64'(0));
    tick;
    applyStimulus(3'b111, 3'b111, 1'b0);
    rst = 1'b1;
    #2;
    checkOutput($sformatf("rst%0d idle after", victim), 64'(gnt_o), 64'(0));
    tick;
    #2;
    checkOutput($sformatf("rst%0d first gnt", victim), 64'(gnt_o), 64'(3'b001));
    applyStimulus(3'b000, 3'b000, 1'b0);
    tick;
    tick;
  endtask

  initial begin
    // Vectors from reset: all three contend, then m1 alone, then m0 holds
    // the bus for four back-to-back acks while m1 waits.
    vecs[0]  = '{3'b111, 3'b111, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 32'h0,         1'b0};
    vecs[1]  = '{3'b111, 3'b111, 1'b1, 3'b001, 3'b001, 3'b000, 1'b1, 32'h1000_0000, 1'b0};
    vecs[2]  = '{3'b110, 3'b110, 1'b0, 3'b001, 3'b000, 3'b000, 1'b0, 32'h1000_0000, 1'b0};
    vecs[3]  = '{3'b110, 3'b110, 1'b1, 3'b010, 3'b010, 3'b000, 1'b1, 32'h2000_0000, 1'b0};
    vecs[4]  = '{3'b100, 3'b100, 1'b0, 3'b010, 3'b000, 3'b000, 1'b0, 32'h2000_0000, 1'b0};
    vecs[5]  = '{3'b101, 3'b101, 1'b1, 3'b100, 3'b100, 3'b000, 1'b1, 32'h3000_0000, 1'b0};
    vecs[6]  = '{3'b001, 3'b001, 1'b0, 3'b100, 3'b000, 3'b000, 1'b0, 32'h3000_0000, 1'b0};
    vecs[7]  = '{3'b001, 3'b001, 1'b1, 3'b001, 3'b001, 3'b000, 1'b1, 32'h1000_0000, 1'b0};
    vecs[8]  = '{3'b000, 3'b000, 1'b0, 3'b001, 3'b000, 3'b000, 1'b0, 32'h1000_0000, 1'b0};
    vecs[9]  = '{3'b010, 3'b010, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 32'h0,         1'b0};
    vecs[10] = '{3'b010, 3'b010, 1'b1, 3'b010, 3'b010, 3'b000, 1'b1, 32'h2000_0000, 1'b0};
    vecs[11] = '{3'b000, 3'b000, 1'b0, 3'b010, 3'b000, 3'b000, 1'b0, 32'h2000_0000, 1'b0};
    vecs[12] = '{3'b011, 3'b011, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 32'h0,         1'b0};
    vecs[13] = '{3'b011, 3'b011, 1'b1, 3'b001, 3'b001, 3'b000, 1'b1, 32'h1000_0000, 1'b0};
    vecs[14] = '{3'b011, 3'b011, 1'b1, 3'b001, 3'b001, 3'b000, 1'b1, 32'h1000_0000, 1'b0};
    vecs[15] = '{3'b011, 3'b011, 1'b1, 3'b001, 3'b001, 3'b000, 1'b1, 32'h1000_0000, 1'b0};
    vecs[16] = '{3'b011, 3'b011, 1'b1, 3'b001, 3'b001, 3'b000, 1'b1, 32'h1000_0000, 1'b0};
    vecs[17] = '{3'b010, 3'b010, 1'b0, 3'b001, 3'b000, 3'b000, 1'b0, 32'h1000_0000, 1'b0};
    vecs[18] = '{3'b010, 3'b010, 1'b1, 3'b010, 3'b010, 3'b000, 1'b1, 32'h2000_0000, 1'b0};
    vecs[19] = '{3'b000, 3'b000, 1'b0, 3'b010, 3'b000, 3'b000, 1'b0, 32'h2000_0000, 1'b0};

    rst = 1'b0;
    loadFixedPayload();
    applyStimulus(3'b000, 3'b000, 1'b0);
    #1;
    checkOutput("reset gnt",   64'(gnt_o),     64'(0));
    checkOutput("reset s_cyc", 64'(s_cyc_o),   64'(0));
    checkOutput("reset s_adr", 64'(s_adr_o),   64'(0));
    checkOutput("reset ack",   64'(m_ack_o),   64'(0));
    checkOutput("reset err",   64'(m_err_o),   64'(0));
    checkOutput("reset tmo",   64'(timeout_o), 64'(0));
    checkOutput("reset m_dat", 64'(m_dat_o),   64'(32'hCAFE_0000));
    tick;
    tick;
    rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].cyc, vecs[i].stb, vecs[i].ack);
      #2;
      checkOutput($sformatf("vec%0d gnt", i),   64'(gnt_o),     64'(vecs[i].gnt));
      checkOutput($sformatf("vec%0d ack", i),   64'(m_ack_o),   64'(vecs[i].acko));
      checkOutput($sformatf("vec%0d err", i),   64'(m_err_o),   64'(vecs[i].erro));
      checkOutput($sformatf("vec%0d s_stb", i), 64'(s_stb_o),   64'(vecs[i].sstb));
      checkOutput($sformatf("vec%0d s_adr", i), 64'(s_adr_o),   64'(vecs[i].adr));
      checkOutput($sformatf("vec%0d tmo", i),   64'(timeout_o), 64'(vecs[i].tmo));
      tick;
    end

    // Slave never acks: the 16th stb cycle is terminated with err.
    applyStimulus(3'b100, 3'b100, 1'b0);
    #2;
    checkOutput("wd pre gnt", 64'(gnt_o), 64'(0));
    tick;
    for (int i = 1; i <= 17; i++) begin
      applyStimulus(3'b100, 3'b100, 1'b0);
      #2;
      checkOutput($sformatf("wd%0d gnt", i),   64'(gnt_o),     64'(3'b100));
      checkOutput($sformatf("wd%0d err", i),   64'(m_err_o),   64'((i == 16) ? 3'b100 : 3'b000));
      checkOutput($sformatf("wd%0d s_stb", i), 64'(s_stb_o),   64'(i != 16));
      checkOutput($sformatf("wd%0d s_cyc", i), 64'(s_cyc_o),   64'(i != 16));
      checkOutput($sformatf("wd%0d tmo", i),   64'(timeout_o), 64'(i == 16));
      tick;
    end
    applyStimulus(3'b000, 3'b000, 1'b0);
    tick;

    // Ack arrives exactly on the 16th stb cycle: ack wins, no err.
    applyStimulus(3'b100, 3'b100, 1'b0);
    tick;
    for (int i = 1; i <= 17; i++) begin
      applyStimulus(3'b100, 3'b100, (i == 16));
      #2;
      checkOutput($sformatf("wa%0d ack", i),   64'(m_ack_o),   64'((i == 16) ? 3'b100 : 3'b000));
      checkOutput($sformatf("wa%0d err", i),   64'(m_err_o),   64'(0));
      checkOutput($sformatf("wa%0d tmo", i),   64'(timeout_o), 64'(0));
      checkOutput($sformatf("wa%0d s_stb", i), 64'(s_stb_o),   64'(1));
      tick;
    end
    applyStimulus(3'b000, 3'b000, 1'b0);
    tick;

    resetMidCycle(2);
    resetMidCycle(1);

    // Randomized traffic against the reference model.
    rst = 1'b0;
    tick;
    rst = 1'b1;
    modelReset();
    rnd_cyc = '0;
    rnd_stb = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < NM; k++) begin
        logic [2:0] mask;
        bit         on;
        mask = 3'(1 << k);
        if ($urandom_range(7) == 0) rnd_cyc = rnd_cyc ^ mask;
        if ((rnd_cyc & mask) != 3'b000) on = ($urandom_range(3) != 0);
        else                            on = ($urandom_range(7) == 0);
        rnd_stb = on ? (rnd_stb | mask) : (rnd_stb & ~mask);
      end
      rnd_ack = ((n / 400) % 2 == 0) ? ($urandom_range(1) == 0) : ($urandom_range(15) == 0);
      m_adr_i = {$urandom, $urandom, $urandom};
      m_dat_i = {$urandom, $urandom, $urandom};
      m_sel_i = 12'($urandom);
      m_we_i  = 3'($urandom);
      s_dat_i = $urandom;
      applyStimulus(rnd_cyc, rnd_stb, rnd_ack);
      #2;
      checkAgainstModel(n);
      @(posedge clk);
      modelStep();
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
